// File: rtl/branch_ctrl_pkg.sv
// Shared constants and types for the branch/sequencing control unit.
package branch_ctrl_pkg;

    // Instruction field encodings
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_JMP   = 3'b111;
    localparam logic [1:0] SUB_BR   = 2'b00;
    localparam logic [1:0] SUB_HALT = 2'b11;

    // Default target-LUT geometry
    localparam int unsigned LUT_AW_DEF = 4;
    localparam int unsigned LUT_DEPTH  = 2 ** LUT_AW_DEF;

    // Run-protocol states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/target_lut.sv
// Branch-target register file: synchronous write, asynchronous read, sync clear.
module target_lut
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned A      = 10,
    parameter int unsigned LUT_AW = LUT_AW_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              we,
    input  logic [LUT_AW-1:0] waddr,
    input  logic [A-1:0]      wdata,
    input  logic [LUT_AW-1:0] raddr,
    output logic [A-1:0]      rdata
);

    localparam int unsigned Depth = 2 ** LUT_AW;

    logic [A-1:0] mem [Depth];

    // Clear every entry on reset; otherwise accept a write in any state
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read path sees the pre-edge contents, so a same-cycle write is not forwarded
    assign rdata = mem[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution, Start/Done run sequencing and run-cycle counting.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned A      = 10,
    parameter int unsigned W      = 9,
    parameter int unsigned LUT_AW = LUT_AW_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [W-1:0]      Instr,
    input  logic [A-1:0]      ProgCtr,
    input  logic              zero_flag,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [A-1:0]      lut_wdata,
    output logic              beq_flag,
    output logic              jmp_flag,
    output logic [A-1:0]      Target,
    output logic              Done,
    output logic [15:0]       cycle_cnt
);

    state_t            state;
    logic              done_q;
    logic [15:0]       cnt_q;
    logic [2:0]        op;
    logic [1:0]        sub;
    logic [LUT_AW-1:0] idx;
    logic              is_beq;
    logic              is_jmp;
    logic              is_halt;
    logic              in_run;
    logic [A-1:0]      lut_rdata;

    // PC is observed for debug only; keep it from looking like a dangling input
    logic unused_progctr;
    assign unused_progctr = ^ProgCtr;

    assign op  = Instr[8:6];
    assign sub = Instr[5:4];
    assign idx = Instr[LUT_AW-1:0];

    assign is_beq  = (op == OP_BEQ) && (sub == SUB_BR);
    assign is_jmp  = (op == OP_JMP) && (sub == SUB_BR);
    assign is_halt = (op == OP_JMP) && (sub == SUB_HALT);
    assign in_run  = (state == RUN);

    target_lut #(
        .A      (A),
        .LUT_AW (LUT_AW)
    ) u_target_lut (
        .clk   (clk),
        .Reset (Reset),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (idx),
        .rdata (lut_rdata)
    );

    // Run-protocol FSM with registered Done and saturating run-cycle counter
    always_ff @(posedge clk) begin
        if (Reset) begin
            state  <= IDLE;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= ARMED;
                        cnt_q <= '0;
                    end
                end
                ARMED: begin
                    if (!Start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Abort wins over a HALT in the same cycle
                    if (Start) begin
                        state <= ARMED;
                        cnt_q <= '0;
                    end else begin
                        if (cnt_q != 16'hFFFF) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                        if (is_halt) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (Start) begin
                        state  <= ARMED;
                        done_q <= 1'b0;
                        cnt_q  <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Zero-latency PC controls; Target is shown for a BEQ even when not taken
    always_comb begin
        beq_flag = in_run && is_beq && zero_flag;
        jmp_flag = in_run && is_jmp;
        Target   = (in_run && (is_beq || is_jmp)) ? lut_rdata : '0;
    end

    assign Done      = done_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: per-cycle vector table plus saturation run.
`timescale 1ns/1ps
module tb_branch_ctrl;

    localparam logic [8:0] I_BEQ3 = 9'b110_00_0011;
    localparam logic [8:0] I_JMP5 = 9'b111_00_0101;
    localparam logic [8:0] I_HALT = 9'b111_11_0000;
    localparam logic [8:0] I_NOP  = 9'b000_00_0011;
    localparam logic [8:0] I_ODD  = 9'b110_01_0011;
    localparam int         NVEC   = 36;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [8:0]  Instr;
    logic [9:0]  ProgCtr;
    logic        zero_flag;
    logic        lut_we;
    logic [3:0]  lut_waddr;
    logic [9:0]  lut_wdata;
    logic        beq_flag;
    logic        jmp_flag;
    logic [9:0]  Target;
    logic        Done;
    logic [15:0] cycle_cnt;

    typedef struct {
        logic        rst;
        logic        start;
        logic [8:0]  instr;
        logic        zero;
        logic        we;
        logic [3:0]  waddr;
        logic [9:0]  wdata;
        logic        beq;
        logic        jmp;
        logic [9:0]  tgt;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [NVEC];
    vec_t sb_q [$];
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk       (clk),
        .Reset     (Reset),
        .Start     (Start),
        .Instr     (Instr),
        .ProgCtr   (ProgCtr),
        .zero_flag (zero_flag),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .beq_flag  (beq_flag),
        .jmp_flag  (jmp_flag),
        .Target    (Target),
        .Done      (Done),
        .cycle_cnt (cycle_cnt)
    );

    function automatic vec_t mk(input logic rst, input logic start, input logic [8:0] instr,
                                input logic zero, input logic we, input logic [3:0] waddr,
                                input logic [9:0] wdata, input logic beq, input logic jmp,
                                input logic [9:0] tgt, input logic done,
                                input logic [15:0] cnt);
        vec_t v;
        v.rst = rst;  v.start = start; v.instr = instr; v.zero = zero;
        v.we = we;    v.waddr = waddr; v.wdata = wdata;
        v.beq = beq;  v.jmp = jmp;     v.tgt = tgt;     v.done = done; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        chk({tag, " beq"},    {15'd0, beq_flag}, {15'd0, e.beq});
        chk({tag, " jmp"},    {15'd0, jmp_flag}, {15'd0, e.jmp});
        chk({tag, " target"}, {6'd0, Target},    {6'd0, e.tgt});
        chk({tag, " done"},   {15'd0, Done},     {15'd0, e.done});
        chk({tag, " cnt"},    cycle_cnt,         e.cnt);
        chk({tag, " excl"},   {15'd0, beq_flag & jmp_flag}, 16'd0);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare mid-cycle
    task automatic apply(input int i);
        vec_t e;
        @(posedge clk);
        #1;
        Reset     = vecs[i].rst;
        Start     = vecs[i].start;
        Instr     = vecs[i].instr;
        zero_flag = vecs[i].zero;
        lut_we    = vecs[i].we;
        lut_waddr = vecs[i].waddr;
        lut_wdata = vecs[i].wdata;
        ProgCtr   = 10'(i);
        sb_q.push_back(vecs[i]);
        @(negedge clk);
        e = sb_q.pop_front();
        check_all($sformatf("row%0d", i), e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //             rst st instr  z  we ad wdata  beq jmp tgt  dn cnt
        vecs[0]  = mk(0, 0, I_JMP5, 0, 1, 3, 10'd10, 0, 0, 0,  0, 0);
        vecs[1]  = mk(0, 0, I_BEQ3, 1, 1, 5, 10'd20, 0, 0, 0,  0, 0);
        vecs[2]  = mk(0, 1, I_JMP5, 1, 0, 0, 10'd0,  0, 0, 0,  0, 0);
        vecs[3]  = mk(0, 0, I_JMP5, 1, 0, 0, 10'd0,  0, 0, 0,  0, 0);
        vecs[4]  = mk(0, 0, I_BEQ3, 1, 0, 0, 10'd0,  1, 0, 10, 0, 0);
        vecs[5]  = mk(0, 0, I_BEQ3, 0, 0, 0, 10'd0,  0, 0, 10, 0, 1);
        vecs[6]  = mk(0, 0, I_JMP5, 0, 0, 0, 10'd0,  0, 1, 20, 0, 2);
        vecs[7]  = mk(0, 0, I_JMP5, 1, 0, 0, 10'd0,  0, 1, 20, 0, 3);
        vecs[8]  = mk(0, 0, I_BEQ3, 1, 1, 3, 10'd7,  1, 0, 10, 0, 4);
        vecs[9]  = mk(0, 0, I_BEQ3, 1, 0, 0, 10'd0,  1, 0, 7,  0, 5);
        vecs[10] = mk(0, 0, I_NOP,  1, 0, 0, 10'd0,  0, 0, 0,  0, 6);
        vecs[11] = mk(0, 0, I_ODD,  1, 0, 0, 10'd0,  0, 0, 0,  0, 7);
        vecs[12] = mk(0, 0, I_HALT, 1, 0, 0, 10'd0,  0, 0, 0,  0, 8);
        vecs[13] = mk(0, 0, I_JMP5, 1, 0, 0, 10'd0,  0, 0, 0,  1, 9);
        vecs[14] = mk(0, 0, I_NOP,  0, 0, 0, 10'd0,  0, 0, 0,  1, 9);
        vecs[15] = mk(0, 1, I_NOP,  0, 0, 0, 10'd0,  0, 0, 0,  1, 9);
        vecs[16] = mk(0, 0, I_NOP,  0, 0, 0, 10'd0,  0, 0, 0,  0, 0);
        vecs[17] = mk(0, 0, I_NOP,  0, 0, 0, 10'd0,  0, 0, 0,  0, 0);
        vecs[18] = mk(0, 0, I_NOP,  1, 0, 0, 10'd0,  0, 0, 0,  0, 1);
        vecs[19] = mk(0, 0, I_ODD,  1, 0, 0, 10'd0,  0, 0, 0,  0, 2);
        vecs[20] = mk(0, 0, I_NOP,  0, 0, 0, 10'd0,  0, 0, 0,  0, 3);
        vecs[21] = mk(0, 0, I_NOP,  0, 0, 0, 10'd0,  0, 0, 0,  0, 4);
        vecs[22] = mk(0, 0, I_HALT, 0, 0, 0, 10'd0,  0, 0, 0,  0, 5);
        vecs[23] = mk(0, 0, I_JMP5, 0, 0, 0, 10'd0,  0, 0, 0,  1, 6);
        vecs[24] = mk(0, 1, I_JMP5, 0, 0, 0, 10'd0,  0, 0, 0,  1, 6);
        vecs[25] = mk(0, 1, I_JMP5, 0, 0, 0, 10'd0,  0, 0, 0,  0, 0);
        vecs[26] = mk(0, 0, I_JMP5, 0, 0, 0, 10'd0,  0, 0, 0,  0, 0);
        vecs[27] = mk(0, 0, I_JMP5, 0, 0, 0, 10'd0,  0, 1, 20, 0, 0);
        // Reset mid-run: flags stay up until the edge, then everything clears
        vecs[28] = mk(1, 0, I_JMP5, 0, 1, 5, 10'd99, 0, 1, 20, 0, 1);
        vecs[29] = mk(0, 0, I_JMP5, 0, 0, 0, 10'd0,  0, 0, 0,  0, 0);
        vecs[30] = mk(0, 1, I_JMP5, 0, 0, 0, 10'd0,  0, 0, 0,  0, 0);
        vecs[31] = mk(0, 0, I_JMP5, 0, 0, 0, 10'd0,  0, 0, 0,  0, 0);
        vecs[32] = mk(0, 0, I_JMP5, 0, 0, 0, 10'd0,  0, 1, 0,  0, 0);
        // Start and HALT together: abort wins, Done never rises
        vecs[33] = mk(0, 1, I_HALT, 0, 0, 0, 10'd0,  0, 0, 0,  0, 1);
        vecs[34] = mk(0, 0, I_HALT, 0, 0, 0, 10'd0,  0, 0, 0,  0, 0);
        vecs[35] = mk(0, 0, I_NOP,  0, 0, 0, 10'd0,  0, 0, 0,  0, 0);

        Reset = 1'b1; Start = 1'b0; Instr = I_JMP5; ProgCtr = '0;
        zero_flag = 1'b1; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset done", {15'd0, Done}, 16'd0);
        chk("reset cnt", cycle_cnt, 16'd0);
        chk("reset jmp", {15'd0, jmp_flag}, 16'd0);
        chk("reset target", {6'd0, Target}, 16'd0);

        for (int i = 0; i < NVEC; i++) begin
            apply(i);
        end

        // Still in RUN with a non-control instruction: run toward saturation
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat pre", cycle_cnt, 16'hFFFE);
        @(posedge clk);
        @(negedge clk);
        chk("sat hit", cycle_cnt, 16'hFFFF);
        repeat (4465) @(posedge clk);
        @(negedge clk);
        chk("sat hold", cycle_cnt, 16'hFFFF);
        chk("sat done", {15'd0, Done}, 16'd0);

        @(posedge clk); #1; Instr = I_HALT;
        @(posedge clk); #1; Instr = I_JMP5;
        @(negedge clk);
        chk("sat halt done", {15'd0, Done}, 16'd1);
        chk("sat halt cnt", cycle_cnt, 16'hFFFF);
        chk("sat halt jmp", {15'd0, jmp_flag}, 16'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequencing and branch-resolution unit that drives the program counter's control inputs (beq_flag, jmp_flag, Target) from the fetched instruction and the ALU zero flag.
- Holds a 16-entry branch-target lookup table, loaded by a write port before the run.
- Runs the Start/Done run protocol and counts run cycles.
- Sits between instruction ROM/ALU and the program counter, as its control-side counterpart.

Parameters:
A, 10, program-counter / target width
W, 9, instruction width
LUT_AW, 4, target-LUT index width (depth 2**LUT_AW = 16)

Ports:
clk  input  1  clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  high = arm/hold; falling edge (high then low) begins run
Instr  input  W  instruction at current ProgCtr
ProgCtr  input  A  current PC (monitoring only; reported in no output)
zero_flag  input  1  ALU zero result for current instruction
lut_we  input  1  target-LUT write enable
lut_waddr  input  LUT_AW  LUT write index
lut_wdata  input  A  LUT write data
beq_flag  output  1  conditional branch taken
jmp_flag  output  1  unconditional jump
Target  output  A  branch/jump target address
Done  output  1  program halted (registered)
cycle_cnt  output  16  run-cycle count (registered)

Behaviour:
- Decode: op = Instr[8:6], sub = Instr[5:4], idx = Instr[3:0].
  - op=110, sub=00: BEQ.
  - op=111, sub=00: JMP.
  - op=111, sub=11: HALT.
  - All others: non-control.
- FSM states: IDLE, ARMED, RUN, DONE. Reset state is IDLE.
  - IDLE: Start=1 -> ARMED.
  - ARMED: Start=0 -> RUN.
  - RUN: Start=1 -> ARMED (abort). Else HALT decoded -> DONE. Start takes priority over HALT.
  - DONE: Start=1 -> ARMED. Otherwise stay in DONE.
- Flags are combinational, zero-latency, valid in the same cycle as Instr; the program counter samples them at the next edge.
  - beq_flag = (state==RUN) & BEQ & zero_flag.
  - jmp_flag = (state==RUN) & JMP.
  - Never both high.
  - Target = lut[idx] when (state==RUN) & (BEQ|JMP), else 0. Target is independent of zero_flag, so a BEQ that is not taken still presents lut[idx].
  - Outside RUN: both flags 0 and Target 0 regardless of Instr.
- Done = registered (state==DONE). It rises on the first edge after HALT is sampled in RUN and falls on the edge that enters ARMED.
- cycle_cnt:
  - Cleared on the edge entering ARMED.
  - Increments once per edge taken while in RUN, including the HALT cycle.
  - Saturates at 16'hFFFF with no wrap.
  - Holds its value in DONE and IDLE.
- Target LUT:
  - Synchronous write, asynchronous read.
  - A write in cycle N becomes visible from cycle N+1; a same-cycle read of the same index returns the old value.
  - Writes are accepted in every state.
- Reset, on the edge: state=IDLE, Done=0, cycle_cnt=0, all LUT entries=0. Reset has priority over lut_we and Start.
- Reset mid-RUN: flags drop to 0 combinationally, since state becomes IDLE at the reset edge.
- Run sequence from reset: Reset, then Start high for at least 1 cycle, then Start low. The first RUN cycle is the cycle after Start is sampled low.

Decomposition:
- Package branch_ctrl_pkg holds:
  - Opcode/sub constants: OP_BEQ=3'b110, OP_JMP=3'b111, SUB_BR=2'b00, SUB_HALT=2'b11.
  - State enum (IDLE, ARMED, RUN, DONE).
  - LUT_DEPTH.
- Sub-module target_lut:
  - 2**LUT_AW x A register file.
  - Sync write, async read, sync clear on Reset.
- FSM, decode and counter stay in branch_ctrl.

Test Plan:
- Reset, then load lut[3]=10'd10 and lut[5]=10'd20; Start pulse 1 cycle; Instr=9'b110_00_0011 with zero_flag=1 -> beq_flag=1, Target=10, jmp_flag=0. Same instruction with zero_flag=0 -> beq_flag=0, Target=10.
- In RUN, Instr=9'b111_00_0101 -> jmp_flag=1, Target=20, independent of zero_flag. Same instruction in ARMED or IDLE -> both flags 0, Target=0.
- Start pulse, 5 non-control instructions, then HALT 9'b111_11_0000 -> Done=1 on the next edge, cycle_cnt=6, flags 0 afterwards. Start=1 -> Done=0 and cycle_cnt=0 on that edge.
- Write lut[3]=10'd7 in the same cycle a BEQ idx=3 is presented with the old value 10 -> Target=10 that cycle and 7 the next.
- Assert Reset mid-RUN during a JMP -> next cycle state IDLE, jmp_flag=0, Done=0, cycle_cnt=0, and a read of lut[5] after the next Start returns 0.
- Hold RUN with no HALT for 70000 cycles -> cycle_cnt saturates at 16'hFFFF. Assert Start in RUN with HALT present in the same cycle -> ARMED, Done stays 0.
